// File: rtl/alu_result_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_uart_tx
// Function : Sends the captured ALU result byte and a flag byte
//            (bit0 = carry, bit1 = zero) as two back-to-back 8N1 UART frames.
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_uart_tx #(
  parameter int NB_DATA      = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int NB_BAUD_CNT  = $clog2(CLKS_PER_BIT)
) (
  input  logic               clock,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_result,
  input  logic               i_zero,
  input  logic               i_carry,
  output logic               o_tx,
  output logic               o_busy,
  output logic               o_done
);

  localparam int NB_BIT_IDX = $clog2(NB_DATA);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [NB_BAUD_CNT-1:0] BAUD_LAST = NB_BAUD_CNT'(CLKS_PER_BIT - 1);
  localparam logic [NB_BIT_IDX-1:0]  BIT_LAST  = NB_BIT_IDX'(NB_DATA - 1);

  logic [1:0]             state, state_nxt;
  logic [NB_BAUD_CNT-1:0] baud_cnt, baud_cnt_nxt;
  logic [NB_BIT_IDX-1:0]  bit_idx, bit_idx_nxt;
  logic                   frame_idx, frame_idx_nxt;
  logic [NB_DATA-1:0]     byte0, byte0_nxt;
  logic [NB_DATA-1:0]     byte1, byte1_nxt;
  logic [NB_DATA-1:0]     next_byte;
  logic                   tx_nxt, busy_nxt, done_nxt;
  logic                   bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);

  // State, datapath and registered outputs; reset forces the line idle-high at once.
  always_ff @(posedge clock or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      frame_idx <= 1'b0;
      byte0     <= '0;
      byte1     <= '0;
      o_tx      <= 1'b1;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      frame_idx <= frame_idx_nxt;
      byte0     <= byte0_nxt;
      byte1     <= byte1_nxt;
      o_tx      <= tx_nxt;
      o_busy    <= busy_nxt;
      o_done    <= done_nxt;
    end
  end

  // Next-state logic: bit timing, bit/frame sequencing and shadow capture.
  always_comb begin
    state_nxt     = state;
    bit_idx_nxt   = bit_idx;
    frame_idx_nxt = frame_idx;
    byte0_nxt     = byte0;
    byte1_nxt     = byte1;
    if (state == ST_IDLE || bit_end) begin
      baud_cnt_nxt = '0;
    end else begin
      baud_cnt_nxt = baud_cnt + NB_BAUD_CNT'(1);
    end
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          state_nxt     = ST_START;
          byte0_nxt     = i_result;
          byte1_nxt     = {{(NB_DATA-2){1'b0}}, i_zero, i_carry};
          frame_idx_nxt = 1'b0;
          bit_idx_nxt   = '0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_nxt   = ST_DATA;
          bit_idx_nxt = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx == BIT_LAST) begin
            state_nxt = ST_STOP;
          end else begin
            bit_idx_nxt = bit_idx + NB_BIT_IDX'(1);
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (!frame_idx) begin
            frame_idx_nxt = 1'b1;
            state_nxt     = ST_START;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the line is driven straight from flops.
  always_comb begin
    next_byte = frame_idx_nxt ? byte1_nxt : byte0_nxt;
    case (state_nxt)
      ST_START: tx_nxt = 1'b0;
      ST_DATA:  tx_nxt = next_byte[bit_idx_nxt];
      default:  tx_nxt = 1'b1;
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = (state == ST_STOP) && (state_nxt == ST_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_result_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_uart_tx
// Function : Directed self-checking bench for alu_result_uart_tx (4 clk/bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_uart_tx;

  localparam int NB_DATA      = 8;
  localparam int CLKS_PER_BIT = 4;
  localparam int LOG_LEN      = 256;

  logic               clock;
  logic               i_rst;
  logic               i_start;
  logic [NB_DATA-1:0] i_result;
  logic               i_zero;
  logic               i_carry;
  logic               o_tx;
  logic               o_busy;
  logic               o_done;

  int checks;
  int errors;

  logic tx_log   [0:LOG_LEN-1];
  logic busy_log [0:LOG_LEN-1];
  logic done_log [0:LOG_LEN-1];

  alu_result_uart_tx #(
    .NB_DATA      (NB_DATA),
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) dut (
    .clock    (clock),
    .i_rst    (i_rst),
    .i_start  (i_start),
    .i_result (i_result),
    .i_zero   (i_zero),
    .i_carry  (i_carry),
    .o_tx     (o_tx),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands and raise start one half-cycle before the accepting edge.
  task automatic launch(input logic [7:0] res, input logic z, input logic c);
    @(negedge clock);
    i_result = res;
    i_zero   = z;
    i_carry  = c;
    i_start  = 1'b1;
    @(posedge clock);
  endtask

  // Log outputs at each falling edge; index j is the cycle after accepting edge k+j.
  task automatic record(input int n, input bit hold, input int poke);
    for (int j = 0; j < n; j++) begin
      @(negedge clock);
      tx_log[j]   = o_tx;
      busy_log[j] = o_busy;
      done_log[j] = o_done;
      if (j == 0 && !hold) i_start = 1'b0;
      if (poke >= 0 && j == poke) begin
        i_start  = 1'b1;
        i_result = 8'hFF;
        i_zero   = 1'b1;
        i_carry  = 1'b1;
      end
      if (poke >= 0 && j == poke + 1) i_start = 1'b0;
    end
  endtask

  // Bench receiver: samples mid-bit of a frame beginning at log index base.
  function automatic logic [7:0] decode(input int base);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = tx_log[base + (i + 1) * CLKS_PER_BIT + 2];
    return b;
  endfunction

  function automatic logic [1:0] framing(input int base);
    return {tx_log[base + 2], tx_log[base + 9 * CLKS_PER_BIT + 2]};
  endfunction

  function automatic int count_done(input int n);
    int c = 0;
    for (int j = 0; j < n; j++) if (done_log[j]) c++;
    return c;
  endfunction

  task automatic wait_idle(input string tag);
    int cyc = 0;
    while (o_busy && cyc < 500) begin
      @(negedge clock);
      cyc++;
    end
    check(tag, {31'b0, o_busy}, 32'd0);
    repeat (3) @(negedge clock);
  endtask

  initial begin
    logic [0:19] exp_seq;
    int bad;
    checks   = 0;
    errors   = 0;
    i_rst    = 1'b1;
    i_start  = 1'b0;
    i_result = '0;
    i_zero   = 1'b0;
    i_carry  = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_tx",   {31'b0, o_tx},   32'd1);
    check("rst_busy", {31'b0, o_busy}, 32'd0);
    check("rst_done", {31'b0, o_done}, 32'd0);
    i_rst = 1'b0;
    bad = 0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clock);
      if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) bad++;
    end
    check("idle_line", bad, 0);

    // Basic frame: 0xA5, flags carry only -> 0x01
    launch(8'hA5, 1'b0, 1'b1);
    record(90, 1'b0, -1);
    exp_seq = 20'b0101001011_0100000001;
    bad = 0;
    for (int j = 0; j < 80; j++) if (tx_log[j] !== exp_seq[j / CLKS_PER_BIT]) bad++;
    check("basic_seq", bad, 0);
    bad = 0;
    for (int j = 0; j < 80; j++) if (busy_log[j] !== 1'b1 || done_log[j] !== 1'b0) bad++;
    check("basic_busy80", bad, 0);
    check("basic_busy_end", {31'b0, busy_log[80]}, 32'd0);
    check("basic_done",     {31'b0, done_log[80]}, 32'd1);
    check("basic_done_one", count_done(90), 1);
    check("basic_tx_idle",  {31'b0, tx_log[80]}, 32'd1);
    check("basic_b0", {24'b0, decode(0)},  32'hA5);
    check("basic_b1", {24'b0, decode(40)}, 32'h01);
    wait_idle("basic_idle_to");

    // Zero flag
    launch(8'h00, 1'b1, 1'b0);
    record(90, 1'b0, -1);
    check("zero_b0",    {24'b0, decode(0)},  32'h00);
    check("zero_b1",    {24'b0, decode(40)}, 32'h02);
    check("zero_frm0",  {30'b0, framing(0)},  32'd1);
    check("zero_frm1",  {30'b0, framing(40)}, 32'd1);
    check("zero_done",  {31'b0, done_log[80]}, 32'd1);
    wait_idle("zero_idle_to");

    // Start while busy is ignored, and mid-frame operand changes have no effect
    launch(8'h5A, 1'b0, 1'b0);
    record(120, 1'b0, 30);
    check("busy_b0",       {24'b0, decode(0)},  32'h5A);
    check("busy_b1",       {24'b0, decode(40)}, 32'h00);
    check("busy_done_at",  {31'b0, done_log[80]}, 32'd1);
    check("busy_done_one", count_done(120), 1);
    check("busy_no_retx",  {31'b0, busy_log[100]}, 32'd0);
    wait_idle("busy_idle_to");

    // Back-to-back with start held high
    launch(8'h3C, 1'b0, 1'b0);
    record(200, 1'b1, -1);
    i_start = 1'b0;
    check("b2b_done80",  {31'b0, done_log[80]}, 32'd1);
    check("b2b_gap_hi",  {31'b0, tx_log[80]},   32'd1);
    check("b2b_start81", {31'b0, tx_log[81]},   32'd0);
    check("b2b_busy81",  {31'b0, busy_log[81]}, 32'd1);
    check("b2b_b0", {24'b0, decode(0)},   32'h3C);
    check("b2b_b1", {24'b0, decode(40)},  32'h00);
    check("b2b_b2", {24'b0, decode(81)},  32'h3C);
    check("b2b_b3", {24'b0, decode(121)}, 32'h00);
    check("b2b_done161", {31'b0, done_log[161]}, 32'd1);
    wait_idle("b2b_idle_to");

    // Reset mid-frame: 0x96 bit5 is 0, so the line is low just before reset
    launch(8'h96, 1'b1, 1'b1);
    record(26, 1'b0, -1);
    check("rmid_pre_tx", {31'b0, tx_log[25]}, 32'd0);
    #1 i_rst = 1'b1;
    #1;
    check("rmid_tx",   {31'b0, o_tx},   32'd1);
    check("rmid_busy", {31'b0, o_busy}, 32'd0);
    repeat (2) @(negedge clock);
    i_rst = 1'b0;
    bad = 0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clock);
      if (o_done !== 1'b0 || o_tx !== 1'b1 || o_busy !== 1'b0) bad++;
    end
    check("rmid_quiet", bad, 0);
    launch(8'h96, 1'b1, 1'b1);
    record(90, 1'b0, -1);
    check("rmid_b0",   {24'b0, decode(0)},  32'h96);
    check("rmid_b1",   {24'b0, decode(40)}, 32'h03);
    check("rmid_done", {31'b0, done_log[80]}, 32'd1);
    wait_idle("rmid_idle_to");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
